// File: rtl/riscv_if_pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch PC sequencer.
package riscv_if_pc_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   // Canonical RISC-V NOP (addi x0, x0, 0), delivered in place of faulted fetches
   localparam logic [31:0] INST_NOP = 32'h0000_0013;
   localparam int unsigned PC_STEP  = 4;

endpackage

// File: rtl/riscv_if_pc_fetch_if.sv
// Instruction-memory request/response channels plus the fetch-to-decode channel.
interface riscv_if_pc_fetch_if #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned INST_WIDTH = 32
);

   logic                  o_imem_req_valid;
   logic                  i_imem_req_ready;
   logic [DATA_WIDTH-1:0] o_imem_addr;
   logic                  i_imem_rsp_valid;
   logic                  o_imem_rsp_ready;
   logic [INST_WIDTH-1:0] i_imem_rsp_data;
   logic                  i_imem_rsp_err;
   logic                  o_inst_valid;
   logic                  i_inst_ready;
   logic [INST_WIDTH-1:0] o_inst;
   logic [DATA_WIDTH-1:0] o_inst_pc;
   logic                  o_inst_err;

   // Fetch unit side
   modport master (
      output o_imem_req_valid, o_imem_addr, o_imem_rsp_ready,
             o_inst_valid, o_inst, o_inst_pc, o_inst_err,
      input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
             i_imem_rsp_err, i_inst_ready
   );

   // Memory / decode side
   modport slave (
      input  o_imem_req_valid, o_imem_addr, o_imem_rsp_ready,
             o_inst_valid, o_inst, o_inst_pc, o_inst_err,
      output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
             i_imem_rsp_err, i_inst_ready
   );

endinterface

// File: rtl/riscv_if_pc_fetch.sv
// Fetch PC sequencer: one outstanding imem read, delivers instruction+PC to decode,
// and restarts at the execute-stage redirect target, dropping stale data.
module riscv_if_pc_fetch
   import riscv_if_pc_fetch_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH = 64,
   parameter int unsigned          INST_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC  = {DATA_WIDTH{1'b0}}
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_jump_branch,
   input  logic [DATA_WIDTH-1:0] i_target_pc,
   riscv_if_pc_fetch_if.master   fetch_bus
);

   fetch_state_t          state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] pend_pc_q, pend_pc_d;
   logic                  stale_q, stale_d;
   logic                  req_valid_q;
   logic                  rsp_ready_q;
   logic                  hold_q;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic [DATA_WIDTH-1:0] inst_pc_q;
   logic                  inst_err_q;
   logic                  cap_d;
   logic [DATA_WIDTH-1:0] tgt_s;
   logic                  unused_tgt_s;

   // Compressed instructions are unsupported, so targets are word aligned
   assign tgt_s        = {i_target_pc[DATA_WIDTH-1:2], 2'b00};
   assign unused_tgt_s = ^i_target_pc[1:0];

   // Next-state, PC and redirect bookkeeping; redirect outranks every other event
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;
      stale_d   = stale_q;
      cap_d     = 1'b0;
      inst_d    = fetch_bus.i_imem_rsp_data;
      if (fetch_bus.i_imem_rsp_err) begin
         inst_d = INST_WIDTH'(INST_NOP);
      end else begin
         inst_d = fetch_bus.i_imem_rsp_data;
      end
      case (state_q)
         IDLE: begin
            if (i_jump_branch) begin
               pc_d = tgt_s;
            end else begin
               pc_d = pc_q;
            end
            state_d = REQ;
         end
         REQ: begin
            // The request already on the bus keeps its address; its response is marked stale
            if (i_jump_branch) begin
               stale_d   = 1'b1;
               pend_pc_d = tgt_s;
            end else begin
               stale_d   = stale_q;
            end
            if (fetch_bus.i_imem_req_ready) begin
               state_d = WAIT;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            if (i_jump_branch && fetch_bus.i_imem_rsp_valid) begin
               pc_d    = tgt_s;
               stale_d = 1'b0;
               state_d = REQ;
            end else if (i_jump_branch) begin
               stale_d   = 1'b1;
               pend_pc_d = tgt_s;
            end else if (fetch_bus.i_imem_rsp_valid && stale_q) begin
               pc_d    = pend_pc_q;
               stale_d = 1'b0;
               state_d = REQ;
            end else if (fetch_bus.i_imem_rsp_valid) begin
               cap_d   = 1'b1;
               state_d = HOLD;
            end else begin
               state_d = WAIT;
            end
         end
         HOLD: begin
            if (i_jump_branch) begin
               pc_d    = tgt_s;
               state_d = REQ;
            end else if (fetch_bus.i_inst_ready) begin
               pc_d    = pc_q + DATA_WIDTH'(PC_STEP);
               state_d = REQ;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, PC and registered channel outputs
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         pend_pc_q   <= {DATA_WIDTH{1'b0}};
         stale_q     <= 1'b0;
         req_valid_q <= 1'b0;
         rsp_ready_q <= 1'b0;
         hold_q      <= 1'b0;
         inst_q      <= {INST_WIDTH{1'b0}};
         inst_pc_q   <= {DATA_WIDTH{1'b0}};
         inst_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_pc_q   <= pend_pc_d;
         stale_q     <= stale_d;
         req_valid_q <= (state_d == REQ);
         rsp_ready_q <= (state_d == WAIT);
         hold_q      <= (state_d == HOLD);
         if (cap_d) begin
            inst_q     <= inst_d;
            inst_pc_q  <= pc_q;
            inst_err_q <= fetch_bus.i_imem_rsp_err;
         end else begin
            inst_q     <= inst_q;
            inst_pc_q  <= inst_pc_q;
            inst_err_q <= inst_err_q;
         end
      end
   end

   assign fetch_bus.o_imem_req_valid = req_valid_q;
   assign fetch_bus.o_imem_addr      = pc_q;
   assign fetch_bus.o_imem_rsp_ready = rsp_ready_q;
   // A redirect squashes the held instruction in the same cycle
   assign fetch_bus.o_inst_valid     = hold_q & ~i_jump_branch;
   assign fetch_bus.o_inst           = inst_q;
   assign fetch_bus.o_inst_pc        = inst_pc_q;
   assign fetch_bus.o_inst_err       = inst_err_q;

endmodule

// File: tb/tb_riscv_if_pc_fetch.sv
// Directed, table-driven bench for the fetch PC sequencer.
module tb_riscv_if_pc_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        jb;
   logic [63:0] tgt;

   always #5 clk = ~clk;

   riscv_if_pc_fetch_if #(.DATA_WIDTH(64), .INST_WIDTH(32)) bus ();

   riscv_if_pc_fetch #(
      .DATA_WIDTH(64),
      .INST_WIDTH(32),
      .RESET_PC  (64'h0)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_jump_branch(jb),
      .i_target_pc  (tgt),
      .fetch_bus    (bus)
   );

   typedef struct {
      logic        jb;
      logic [63:0] tgt;
      logic        rq_rdy;
      logic        rsp_v;
      logic [31:0] rsp_d;
      logic        rsp_e;
      logic        in_rdy;
      logic        e_rqv;
      logic [63:0] e_addr;
      logic        e_rspr;
      logic        e_iv;
      logic [31:0] e_inst;
      logic [63:0] e_pc;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t mk(input logic j, input logic [63:0] t, input logic rq,
                               input logic rv, input logic [31:0] rd, input logic re,
                               input logic ir, input logic xrv, input logic [63:0] xa,
                               input logic xrr, input logic xiv, input logic [31:0] xi,
                               input logic [63:0] xp, input logic xe);
      vec_t v;
      v.jb = j;      v.tgt = t;      v.rq_rdy = rq; v.rsp_v = rv;
      v.rsp_d = rd;  v.rsp_e = re;   v.in_rdy = ir;
      v.e_rqv = xrv; v.e_addr = xa;  v.e_rspr = xrr; v.e_iv = xiv;
      v.e_inst = xi; v.e_pc = xp;    v.e_err = xe;
      return v;
   endfunction

   task automatic chk(input string nm, input int row, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d actual=%h expected=%h", nm, row, act, exp);
      end
   endtask

   // Drive one cycle's inputs after the falling edge, then settle before sampling
   task automatic step(input logic r, input logic j, input logic [63:0] t, input logic rq,
                       input logic rv, input logic [31:0] rd, input logic re, input logic ir);
      @(negedge clk);
      rst_n                = r;
      jb                   = j;
      tgt                  = t;
      bus.i_imem_req_ready = rq;
      bus.i_imem_rsp_valid = rv;
      bus.i_imem_rsp_data  = rd;
      bus.i_imem_rsp_err   = re;
      bus.i_inst_ready     = ir;
      #1;
   endtask

   task automatic chk_reset(input int row);
      chk("rst_req_valid", row, {63'h0, bus.o_imem_req_valid}, 64'h0);
      chk("rst_addr",      row, bus.o_imem_addr, 64'h0);
      chk("rst_rsp_ready", row, {63'h0, bus.o_imem_rsp_ready}, 64'h0);
      chk("rst_inst_valid", row, {63'h0, bus.o_inst_valid}, 64'h0);
      chk("rst_inst",      row, {32'h0, bus.o_inst}, 64'h0);
      chk("rst_inst_pc",   row, bus.o_inst_pc, 64'h0);
      chk("rst_inst_err",  row, {63'h0, bus.o_inst_err}, 64'h0);
   endtask

   initial begin
      rst_n = 1'b0; jb = 1'b0; tgt = 64'h0;
      bus.i_imem_req_ready = 1'b1; bus.i_imem_rsp_valid = 1'b0;
      bus.i_imem_rsp_data  = 32'h0; bus.i_imem_rsp_err = 1'b0;
      bus.i_inst_ready     = 1'b1;

      //         jb    tgt         rqrdy rspv  rsp_d          err   inrdy  rqv   addr        rspr  iv    inst           pc          ierr
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'h0,   1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b1, 32'hA000_0000, 1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 64'h0,   1'b0, 1'b1, 32'hA000_0000, 64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'h4,   1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b1, 32'hA000_0004, 1'b0, 1'b1, 1'b0, 64'h4,   1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 64'h4,   1'b0, 1'b1, 32'hA000_0004, 64'h4,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'h8,   1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b1, 32'hA000_0008, 1'b0, 1'b1, 1'b0, 64'h8,   1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 64'h8,   1'b0, 1'b1, 32'hA000_0008, 64'h8,   1'b0));
      // redirect to 0x100 while waiting; the late response is dropped
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'hC,   1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b1, 64'h100, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 64'hC,   1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 64'hC,   1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 64'hC,   1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b1, 1'b0, 64'hC,   1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'h100, 1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b1, 32'hA000_0100, 1'b0, 1'b1, 1'b0, 64'h100, 1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      // redirect to 0x201 (aligned to 0x200) while holding with decode stalled
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 64'h100, 1'b0, 1'b1, 32'hA000_0100, 64'h100, 1'b0));
      vecs.push_back(mk(1'b1, 64'h201, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 64'h100, 1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      // redirect in REQ while memory stalls for two cycles
      vecs.push_back(mk(1'b1, 64'h400, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'h200, 1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'h200, 1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'h200, 1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b1, 32'hBAD1_BAD1, 1'b0, 1'b1, 1'b0, 64'h200, 1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'h400, 1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b1, 32'hA000_0400, 1'b0, 1'b1, 1'b0, 64'h400, 1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 64'h400, 1'b0, 1'b1, 32'hA000_0400, 64'h400, 1'b0));
      // two redirects while one request is outstanding: the latest wins
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'h404, 1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b1, 64'h300, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 64'h404, 1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b1, 64'h343, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 64'h404, 1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b1, 32'hBAD2_BAD2, 1'b0, 1'b1, 1'b0, 64'h404, 1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'h340, 1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b1, 32'hA000_0340, 1'b0, 1'b1, 1'b0, 64'h340, 1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      // redirect beats a ready decode; then an error response at 0x40
      vecs.push_back(mk(1'b1, 64'h40,  1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 64'h340, 1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'h40,  1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 64'h40,  1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 64'h40,  1'b0, 1'b1, 32'h0000_0013, 64'h40,  1'b1));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'h44,  1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b1, 32'hA000_0044, 1'b0, 1'b1, 1'b0, 64'h44,  1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 64'h44,  1'b0, 1'b1, 32'hA000_0044, 64'h44,  1'b0));
      // redirect coinciding with a response, then a late response in REQ is ignored
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'h48,  1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b1, 64'h500, 1'b1, 1'b1, 32'hBAD3_BAD3, 1'b0, 1'b1, 1'b0, 64'h48,  1'b1, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b0, 1'b1, 32'hBAD4_BAD4, 1'b0, 1'b1, 1'b1, 64'h500, 1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'h500, 1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 64'h500, 1'b0, 1'b0, 32'h0,         64'h0,   1'b0));
      vecs.push_back(mk(1'b0, 64'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 64'h500, 1'b1, 1'b0, 32'h0,         64'h0,   1'b0));

      repeat (2) @(posedge clk);
      // Reset release cycle: DUT sits in IDLE with reset values
      step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_reset(0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(1'b1, vecs[i].jb, vecs[i].tgt, vecs[i].rq_rdy, vecs[i].rsp_v,
              vecs[i].rsp_d, vecs[i].rsp_e, vecs[i].in_rdy);
         chk("req_valid", i + 1, {63'h0, bus.o_imem_req_valid}, {63'h0, vecs[i].e_rqv});
         chk("addr",      i + 1, bus.o_imem_addr, vecs[i].e_addr);
         chk("rsp_ready", i + 1, {63'h0, bus.o_imem_rsp_ready}, {63'h0, vecs[i].e_rspr});
         chk("inst_valid", i + 1, {63'h0, bus.o_inst_valid}, {63'h0, vecs[i].e_iv});
         if (vecs[i].e_iv) begin
            chk("inst",     i + 1, {32'h0, bus.o_inst}, {32'h0, vecs[i].e_inst});
            chk("inst_pc",  i + 1, bus.o_inst_pc, vecs[i].e_pc);
            chk("inst_err", i + 1, {63'h0, bus.o_inst_err}, {63'h0, vecs[i].e_err});
         end
      end

      // Reset in the middle of a transaction (DUT is in WAIT), late response present
      step(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 32'hBAD5_BAD5, 1'b0, 1'b1);
      // Leave reset with a redirect in IDLE to an unaligned top-of-memory target
      step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_reset(100);
      step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("wrap_req_valid", 101, {63'h0, bus.o_imem_req_valid}, 64'h1);
      chk("wrap_addr",      101, bus.o_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      step(1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 32'hA000_0FFC, 1'b0, 1'b1);
      chk("wrap_rsp_ready", 102, {63'h0, bus.o_imem_rsp_ready}, 64'h1);
      step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("wrap_inst_valid", 103, {63'h0, bus.o_inst_valid}, 64'h1);
      chk("wrap_inst",       103, {32'h0, bus.o_inst}, 64'h0000_0000_A000_0FFC);
      chk("wrap_inst_pc",    103, bus.o_inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("wrap_next_valid", 104, {63'h0, bus.o_imem_req_valid}, 64'h1);
      chk("wrap_next_addr",  104, bus.o_imem_addr, 64'h0);
      chk("wrap_squashed",   104, {63'h0, bus.o_inst_valid}, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
